decoder_sweep: RTL and testbench
================================

Name: decoder_sweep

Overview:
Parametrised, registered N-to-2^N one-hot decoder. It is the successor to the fixed 3-to-8 combinational decoder tree. It drives register-file write-enable lines in the 32-bit RISC datapath. It adds a hardware sweep mode: one start pulse walks every output line in turn, one per cycle, so the register file can be cleared after reset without any software loop.

Parameters:
SEL_W, 5, select width; output width OUT_W = 2**SEL_W (default 32 lines). Legal range 1..6.
ZERO_SKIP, 1, when 1, line 0 is never asserted (register r0 is hardwired zero). When 0, line 0 behaves like any other line.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  decode request for the current cycle
sel  input  SEL_W  line to assert when en=1
sweep_start  input  1  single-cycle request to start a sweep of all lines
y  output  OUT_W  registered one-hot (or all-zero) decode output
y_valid  output  1  registered; high when y has exactly one bit set
sweep_busy  output  1  registered; high on every cycle y is driven by the sweep
sweep_done  output  1  registered; one-cycle pulse after the last sweep line

Behaviour:
- Reset: while rst=1, asynchronously force y=0, y_valid=0, sweep_busy=0, sweep_done=0, state=IDLE, cnt=0. Reset mid-sweep aborts the sweep and no sweep_done is produced.
- Latency: every decode is registered; inputs sampled at edge k appear on y after edge k.
- States: IDLE and SWEEP. Internal counter cnt is SEL_W bits wide.
- FIRST is 1 when ZERO_SKIP=1, otherwise 0.
- IDLE, sweep_start=1 at edge k:
  - y<=onehot(FIRST); cnt<=FIRST+1; sweep_busy<=1; state<=SWEEP.
  - en/sel in the same cycle are discarded (sweep has priority).
- IDLE, sweep_start=0, en=1:
  - y<=onehot(sel); y_valid<=1.
  - Exception: if ZERO_SKIP=1 and sel=0, then y<=0 and y_valid<=0.
- IDLE, sweep_start=0, en=0: y<=0, y_valid<=0.
- SWEEP:
  - en, sel and sweep_start are all ignored.
  - If y currently holds line OUT_W-1: y<=0, y_valid<=0, sweep_busy<=0, sweep_done<=1, state<=IDLE.
  - Otherwise: y<=onehot(cnt); cnt<=cnt+1. cnt wrap past OUT_W-1 is never reached.
- sweep_done is high for exactly one cycle, the cycle after the last line. A sweep_start in that cycle is accepted (back-to-back sweeps allowed).
- y_valid equals the OR-reduce of y at all times; y never has more than one bit set.
- sweep_busy stays high for exactly OUT_W-FIRST consecutive cycles per sweep.
- Output width comes from the OUT_W derivation only; no truncation of sel.

Test Plan:
- Reset then decode (SEL_W=5, ZERO_SKIP=1): en=1, sel=5'd17 -> next cycle y=32'h0002_0000, y_valid=1. Then en=0 -> y=0, y_valid=0.
- ZERO_SKIP check: en=1, sel=0 -> y=0, y_valid=0. Repeat with ZERO_SKIP=0 -> y=32'h1, y_valid=1.
- Full sweep (SEL_W=3, ZERO_SKIP=1): pulse sweep_start -> y steps 8'h02,8'h04,...,8'h80 on 7 consecutive cycles with sweep_busy=1. Next cycle y=0 and sweep_done=1 for one cycle.
- Priority and ignore: sweep_start=1 with en=1, sel=3 -> first y is onehot(FIRST), not 8'h08. en toggling and extra sweep_start mid-sweep -> sequence unchanged.
- Reset mid-sweep: assert rst asynchronously at the 4th sweep line -> y=0 and sweep_busy=0 immediately, sweep_done never pulses. After release, en=1, sel=2 -> y=8'h04.
- Back-to-back: sweep_start in the sweep_done cycle -> a second full 7-line sweep starts on the next cycle with no gap cycle beyond the done cycle.

Source files
------------

// File: rtl/decoder_sweep.sv
// Registered N-to-2^N one-hot decoder with a hardware sweep mode that walks
// every output line once per start pulse (used to clear the register file).
module decoder_sweep #(
    parameter int unsigned SEL_W     = 5,
    parameter bit          ZERO_SKIP = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sweep_start,
    output logic [(2**SEL_W)-1:0] y,
    output logic                  y_valid,
    output logic                  sweep_busy,
    output logic                  sweep_done
);

    localparam int unsigned     OUT_W      = 2**SEL_W;
    localparam logic [SEL_W-1:0] FIRST      = SEL_W'(ZERO_SKIP ? 1 : 0);
    localparam logic [SEL_W-1:0] FIRST_NEXT = SEL_W'((ZERO_SKIP ? 1 : 0) + 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   y_d;
    logic               y_valid_d, sweep_busy_d, sweep_done_d;

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            y          <= '0;
            y_valid    <= 1'b0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            y          <= y_d;
            y_valid    <= y_valid_d;
            sweep_busy <= sweep_busy_d;
            sweep_done <= sweep_done_d;
        end
    end

    // Next-state logic; the sweep ends once the top line has been shown
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sweep_start) state_d = SWEEP;
            SWEEP:   if (y[OUT_W-1])  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next output values; sweep start takes priority over a decode request
    always_comb begin
        cnt_d        = cnt_q;
        y_d          = '0;
        y_valid_d    = 1'b0;
        sweep_busy_d = 1'b0;
        sweep_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sweep_start) begin
                    y_d          = OUT_W'(1) << FIRST;
                    cnt_d        = FIRST_NEXT;
                    y_valid_d    = 1'b1;
                    sweep_busy_d = 1'b1;
                end else if (en && !(ZERO_SKIP && (sel == '0))) begin
                    y_d       = OUT_W'(1) << sel;
                    y_valid_d = 1'b1;
                end
            end
            SWEEP: begin
                if (y[OUT_W-1]) begin
                    sweep_done_d = 1'b1;
                end else begin
                    y_d          = OUT_W'(1) << cnt_q;
                    cnt_d        = cnt_q + SEL_W'(1);
                    y_valid_d    = 1'b1;
                    sweep_busy_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_decoder_sweep.sv
// Bench for decoder_sweep: three parameterisations driven in lockstep and
// compared every cycle against a line-walking reference model.
module tb_decoder_sweep;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        sweep_start = 1'b0;
    logic [4:0]  sel5 = '0;
    logic [2:0]  sel3 = '0;

    logic [31:0] y0, y1;
    logic [7:0]  y2;
    logic        v0, v1, v2, b0, b1, b2, d0, d1, d2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decoder_sweep #(.SEL_W(5), .ZERO_SKIP(1'b1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .sel(sel5), .sweep_start(sweep_start),
        .y(y0), .y_valid(v0), .sweep_busy(b0), .sweep_done(d0));
    decoder_sweep #(.SEL_W(5), .ZERO_SKIP(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .sel(sel5), .sweep_start(sweep_start),
        .y(y1), .y_valid(v1), .sweep_busy(b1), .sweep_done(d1));
    decoder_sweep #(.SEL_W(3), .ZERO_SKIP(1'b1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .sel(sel3), .sweep_start(sweep_start),
        .y(y2), .y_valid(v2), .sweep_busy(b2), .sweep_done(d2));

    // Reference model: number of lines, first swept line, zero-skip flag
    int          ow[3]    = '{32, 32, 8};
    int          first[3] = '{1, 0, 1};
    bit          zs[3]    = '{1'b1, 1'b0, 1'b1};
    bit          in_sw[3];
    int          cur[3];
    logic [63:0] m_y[3];
    bit          m_v[3], m_b[3], m_d[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            in_sw[i] = 1'b0; cur[i] = 0; m_y[i] = '0;
            m_v[i] = 1'b0; m_b[i] = 1'b0; m_d[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit ss, input bit e, input int s);
        m_d[i] = 1'b0;
        if (in_sw[i]) begin
            if (cur[i] == ow[i] - 1) begin
                in_sw[i] = 1'b0; m_y[i] = '0; m_v[i] = 1'b0; m_b[i] = 1'b0; m_d[i] = 1'b1;
            end else begin
                cur[i]++; m_y[i] = 64'd1 << cur[i]; m_v[i] = 1'b1; m_b[i] = 1'b1;
            end
        end else begin
            m_b[i] = 1'b0;
            if (ss) begin
                in_sw[i] = 1'b1; cur[i] = first[i];
                m_y[i] = 64'd1 << cur[i]; m_v[i] = 1'b1; m_b[i] = 1'b1;
            end else if (e && !(zs[i] && s == 0)) begin
                m_y[i] = 64'd1 << s; m_v[i] = 1'b1;
            end else begin
                m_y[i] = '0; m_v[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic compare_all();
        chk("dut0.y", {32'b0, y0}, m_y[0]); chk("dut0.y_valid", 64'(v0), 64'(m_v[0]));
        chk("dut0.busy", 64'(b0), 64'(m_b[0])); chk("dut0.done", 64'(d0), 64'(m_d[0]));
        chk("dut1.y", {32'b0, y1}, m_y[1]); chk("dut1.y_valid", 64'(v1), 64'(m_v[1]));
        chk("dut1.busy", 64'(b1), 64'(m_b[1])); chk("dut1.done", 64'(d1), 64'(m_d[1]));
        chk("dut2.y", {56'b0, y2}, m_y[2]); chk("dut2.y_valid", 64'(v2), 64'(m_v[2]));
        chk("dut2.busy", 64'(b2), 64'(m_b[2])); chk("dut2.done", 64'(d2), 64'(m_d[2]));
    endtask

    task automatic step(input bit ss, input bit e, input logic [4:0] s5, input logic [2:0] s3);
        sweep_start = ss; en = e; sel5 = s5; sel3 = s3;
        @(posedge clk);
        model_step(0, ss, e, int'(s5));
        model_step(1, ss, e, int'(s5));
        model_step(2, ss, e, int'(s3));
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 3'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_len;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset.y2", {56'b0, y2}, 64'h0);
        rst = 1'b0;

        // Plain decode and zero-skip behaviour
        step(1'b0, 1'b1, 5'd17, 3'd5);
        chk("dec17.y0", {32'b0, y0}, 64'h0002_0000);
        chk("dec17.v0", 64'(v0), 64'd1);
        step(1'b0, 1'b0, 5'd17, 3'd5);
        chk("en0.y0", {32'b0, y0}, 64'h0);
        step(1'b0, 1'b1, 5'd0, 3'd0);
        chk("zs1.y0", {32'b0, y0}, 64'h0);
        chk("zs1.v0", 64'(v0), 64'd0);
        chk("zs0.y1", {32'b0, y1}, 64'h1);
        chk("zs0.v1", 64'(v1), 64'd1);
        step(1'b0, 1'b1, 5'd31, 3'd7);
        chk("dec31.y0", {32'b0, y0}, 64'h8000_0000);

        // Full sweep with sweep_start priority over en/sel, inputs ignored mid-sweep
        step(1'b1, 1'b1, 5'd3, 3'd3);
        chk("sweep.first", {56'b0, y2}, 64'h02);
        busy_len = int'(b2);
        for (int k = 2; k < 8; k++) begin
            step(1'(k % 2), 1'(k % 3 == 0), 5'($urandom), 3'($urandom));
            chk("sweep.line", {56'b0, y2}, 64'd1 << k);
            busy_len += int'(b2);
        end
        step(1'b0, 1'b1, 5'd4, 3'd4);
        chk("sweep.done", 64'(d2), 64'd1);
        chk("sweep.done_y", {56'b0, y2}, 64'h0);
        chk("sweep.busy_len", 64'(busy_len), 64'd7);
        step(1'b0, 1'b0, 5'd0, 3'd0);
        chk("sweep.done_once", 64'(d2), 64'd0);
        idle_steps(36);

        // Back-to-back sweeps: restart in the done cycle
        step(1'b1, 1'b0, 5'd0, 3'd0);
        for (int k = 2; k < 8; k++) step(1'b0, 1'b0, 5'd0, 3'd0);
        step(1'b0, 1'b0, 5'd0, 3'd0);
        chk("b2b.done", 64'(d2), 64'd1);
        step(1'b1, 1'b0, 5'd0, 3'd0);
        chk("b2b.restart", {56'b0, y2}, 64'h02);
        chk("b2b.busy", 64'(b2), 64'd1);
        for (int k = 2; k < 8; k++) step(1'b0, 1'b0, 5'd0, 3'd0);
        chk("b2b.last", {56'b0, y2}, 64'h80);
        step(1'b0, 1'b0, 5'd0, 3'd0);
        chk("b2b.done2", 64'(d2), 64'd1);
        idle_steps(36);

        // Asynchronous reset at the 4th sweep line aborts without a done pulse
        step(1'b1, 1'b0, 5'd0, 3'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 5'd0, 3'd0);
        chk("abort.line4", {56'b0, y2}, 64'h10);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("abort.y_async", {56'b0, y2}, 64'h0);
        chk("abort.busy_async", 64'(b2), 64'd0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        idle_steps(10);
        step(1'b0, 1'b1, 5'd2, 3'd2);
        chk("abort.decode2", {56'b0, y2}, 64'h04);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++)
            step(($urandom_range(15) == 0), 1'($urandom), 5'($urandom), 3'($urandom));
        idle_steps(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
